// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic skew feeder: FSM state encoding,
// drain length, stream length and operand slice addressing.
package systolic_skew_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   // PE accumulate register plus PE output register.
   localparam int DRAIN_CYCLES = 2;

   // Cycles needed for the last skewed operand pair to reach PE(n-1,n-1).
   function automatic int stream_len(input int n);
      return 3 * n - 2;
   endfunction

   // LSB position of operand slice idx inside a packed N*DW bus.
   function automatic int slice_lo(input int idx, input int dw);
      return idx * dw;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_slice_mux.sv
// One lane of the skew network: presents element (t - LANE) of the lane's
// buffered operands, or zero when that element is outside 0..N-1.
module skew_slice_mux
   import systolic_skew_feeder_pkg::*;
#(
   parameter int N    = 4,
   parameter int DW   = 8,
   parameter int TW   = 4,
   parameter int LANE = 0
) (
   input  logic [N*DW-1:0] lane_buf,
   input  logic [TW-1:0]   t,
   output logic [DW-1:0]   sel
);

   // Element k is due exactly when t == LANE + k; every other step is zero padding.
   always_comb begin
      sel = '0;
      for (int k = 0; k < N; k++) begin
         if (int'(t) == LANE + k) begin
            sel = lane_buf[slice_lo(k, DW) +: DW];
         end
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Systolic array feeder: collects N column/row beats of A and B, then streams
// them diagonally skewed into the west and north edges of an NxN PE array and
// waits for the result to settle before pulsing done.
module systolic_skew_feeder
   import systolic_skew_feeder_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_a_col,
   input  logic [N*DW-1:0] in_b_row,
   output logic [N*DW-1:0] a_west,
   output logic [N*DW-1:0] b_north,
   output logic            pe_enable,
   output logic            busy,
   output logic            done
);

   localparam int SLEN = stream_len(N);
   localparam int TW   = $clog2(SLEN);
   localparam int KW   = $clog2(N);
   localparam logic [TW-1:0] T_LAST    = TW'(SLEN - 1);
   localparam logic [TW-1:0] D_LAST    = TW'(DRAIN_CYCLES - 1);
   localparam logic [KW-1:0] BEAT_LAST = KW'(N - 1);

   state_t          state_reg, state_next;
   logic [KW-1:0]   beat_reg, beat_next;
   logic [TW-1:0]   t_reg, t_next;
   logic            done_reg, done_next;
   logic [DW-1:0]   a_buf_reg [N][N];
   logic [DW-1:0]   b_buf_reg [N][N];
   logic [N*DW-1:0] a_lane [N];
   logic [N*DW-1:0] b_lane [N];
   logic [N*DW-1:0] a_sel, b_sel;
   logic [N*DW-1:0] a_west_reg, b_north_reg;
   logic            accept;

   assign in_ready  = (state_reg == IDLE) || (state_reg == LOAD);
   assign accept    = in_valid && in_ready;
   assign busy      = (state_reg == STREAM) || (state_reg == DRAIN);
   assign pe_enable = busy;
   assign done      = done_reg;
   assign a_west    = a_west_reg;
   assign b_north   = b_north_reg;

   // State, beat counter, step counter and done pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         beat_reg  <= '0;
         t_reg     <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         t_reg     <= t_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic; t doubles as the drain counter since the two phases never overlap.
   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      t_next     = t_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE, LOAD: begin
            if (accept) begin
               if (beat_reg == BEAT_LAST) begin
                  beat_next  = '0;
                  t_next     = '0;
                  state_next = STREAM;
               end else begin
                  beat_next  = beat_reg + 1'b1;
                  state_next = LOAD;
               end
            end
         end
         STREAM: begin
            if (t_reg == T_LAST) begin
               t_next     = '0;
               state_next = DRAIN;
            end else begin
               t_next = t_reg + 1'b1;
            end
         end
         DRAIN: begin
            if (t_reg == D_LAST) begin
               t_next     = '0;
               done_next  = 1'b1;
               state_next = IDLE;
            end else begin
               t_next = t_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand buffers: beat k fills column k of A and row k of B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               a_buf_reg[i][k] <= '0;
               b_buf_reg[i][k] <= '0;
            end
         end
      end else if (accept) begin
         for (int i = 0; i < N; i++) begin
            a_buf_reg[i][beat_reg] <= in_a_col[slice_lo(i, DW) +: DW];
            b_buf_reg[beat_reg][i] <= in_b_row[slice_lo(i, DW) +: DW];
         end
      end
   end

   // Gather each lane's operands in k order: row i of A, column j of B.
   always_comb begin
      for (int l = 0; l < N; l++) begin
         a_lane[l] = '0;
         b_lane[l] = '0;
         for (int k = 0; k < N; k++) begin
            a_lane[l][slice_lo(k, DW) +: DW] = a_buf_reg[l][k];
            b_lane[l][slice_lo(k, DW) +: DW] = b_buf_reg[k][l];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         skew_slice_mux #(.N(N), .DW(DW), .TW(TW), .LANE(gi)) u_a_mux (
            .lane_buf (a_lane[gi]),
            .t        (t_reg),
            .sel      (a_sel[gi*DW +: DW])
         );
         skew_slice_mux #(.N(N), .DW(DW), .TW(TW), .LANE(gi)) u_b_mux (
            .lane_buf (b_lane[gi]),
            .t        (t_reg),
            .sel      (b_sel[gi*DW +: DW])
         );
      end
   endgenerate

   // Registered edge streams; forced to exact zero whenever no step is being issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_west_reg  <= '0;
         b_north_reg <= '0;
      end else if (state_reg == STREAM) begin
         a_west_reg  <= a_sel;
         b_north_reg <= b_sel;
      end else begin
         a_west_reg  <= '0;
         b_north_reg <= '0;
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomised scoreboard bench for systolic_skew_feeder with a behavioural
// NxN multiply-accumulate PE array attached to the feeder outputs.
module tb_systolic_skew_feeder;

   localparam int N       = 4;
   localparam int DW      = 8;
   localparam int SLEN    = 3 * N - 2;
   localparam int DRAIN   = 2;
   // pe_enable window = STREAM + DRAIN cycles; registered outputs show one
   // leading zero, the SLEN skewed steps, then DRAIN-1 trailing zeros.
   localparam int WIN_LEN = SLEN + DRAIN;

   typedef struct packed {
      logic [N*DW-1:0] a;
      logic [N*DW-1:0] b;
      logic            last;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_a_col;
   logic [N*DW-1:0] in_b_row;
   logic [N*DW-1:0] a_west;
   logic [N*DW-1:0] b_north;
   logic            pe_enable;
   logic            busy;
   logic            done;

   int   checks = 0;
   int   errors = 0;
   int   ma [N][N];
   int   mb [N][N];
   exp_t exp_q [$];
   int   c_q [$];
   bit   mon_en = 0;
   bit   done_due = 0;
   int   mon_beats = 0;
   int   acc_cyc = 0;
   int   ncyc = 0;
   int   nmat = 0;

   systolic_skew_feeder #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a_col  (in_a_col),
      .in_b_row  (in_b_row),
      .a_west    (a_west),
      .b_north   (b_north),
      .pe_enable (pe_enable),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PE array: operands hop east/south one cycle per PE,
   // accumulator clears while disabled, output register follows accumulator.
   logic signed [DW-1:0] pe_ain [N][N];
   logic signed [DW-1:0] pe_bin [N][N];
   logic signed [DW-1:0] pa [N][N];
   logic signed [DW-1:0] pb [N][N];
   logic signed [31:0]   acc [N][N];
   logic signed [31:0]   acc_out [N][N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         pe_ain[i][0] = a_west[i*DW +: DW];
         pe_bin[0][i] = b_north[i*DW +: DW];
         for (int j = 1; j < N; j++) begin
            pe_ain[i][j] = pa[i][j-1];
            pe_bin[j][i] = pb[j-1][i];
         end
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            pa[i][j] <= pe_ain[i][j];
            pb[i][j] <= pe_bin[i][j];
            acc[i][j] <= pe_enable ? (acc[i][j] + 32'(pe_ain[i][j]) * 32'(pe_bin[i][j])) : 32'sd0;
            if (pe_enable) acc_out[i][j] <= acc[i][j];
         end
      end
   end

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at time %0t", name, act, req, $time);
      end
   endtask

   // Reference: skewed edge waveforms and C = A*B from the current ma/mb.
   task automatic push_expected();
      exp_t e;
      int   step;
      int   s;
      for (int c = 0; c < WIN_LEN; c++) begin
         step   = c - 1;
         e.a    = '0;
         e.b    = '0;
         e.last = (c == WIN_LEN - 1);
         if (step >= 0 && step < SLEN) begin
            for (int i = 0; i < N; i++) begin
               if (step - i >= 0 && step - i < N) begin
                  e.a[i*DW +: DW] = DW'(ma[i][step-i]);
                  e.b[i*DW +: DW] = DW'(mb[step-i][i]);
               end
            end
         end
         exp_q.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
            c_q.push_back(s);
         end
      end
   endtask

   // Offers nbeats beats of ma/mb with random idle gaps; leaves in_valid as-is at the end.
   task automatic send_matrix(input int nbeats, input int gap_max);
      logic [N*DW-1:0] ac;
      logic [N*DW-1:0] br;
      int gap;
      int w;
      if (nbeats == N) push_expected();
      for (int k = 0; k < nbeats; k++) begin
         for (int i = 0; i < N; i++) begin
            ac[i*DW +: DW] = DW'(ma[i][k]);
            br[i*DW +: DW] = DW'(mb[k][i]);
         end
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         repeat (gap) begin
            in_valid = 1'b0;
            in_a_col = (N*DW)'($urandom);
            in_b_row = (N*DW)'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_a_col = ac;
         in_b_row = br;
         w = 0;
         while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
         end
         if (w >= 100) chk(1'b0, "ready_timeout", 64'(w), 64'(0));
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((exp_q.size() != 0 || c_q.size() != 0 || busy) && w < 500) begin
         @(posedge clk); #1;
         w++;
      end
      chk(w < 500, "drain_timeout", 64'(w), 64'(500));
   endtask

   task automatic check_quiet(input string tag);
      chk(a_west == '0,  {tag, "_a_west"},    64'(a_west),    64'(0));
      chk(b_north == '0, {tag, "_b_north"},   64'(b_north),   64'(0));
      chk(!pe_enable,    {tag, "_pe_enable"}, 64'(pe_enable), 64'(0));
      chk(!busy,         {tag, "_busy"},      64'(busy),      64'(0));
      chk(!done,         {tag, "_done"},      64'(done),      64'(0));
      chk(in_ready,      {tag, "_in_ready"},  64'(in_ready),  64'(1));
   endtask

   // Asserts reset between clock edges and checks outputs clear before the next edge.
   task automatic apply_reset();
      @(posedge clk); #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_quiet("async_rst");
      exp_q.delete();
      c_q.delete();
      done_due  = 1'b0;
      mon_beats = 0;
      in_valid  = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
   endtask

   task automatic rand_matrix();
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            ma[i][k] = int'($urandom_range(255, 0)) - 128;
            mb[i][k] = int'($urandom_range(255, 0)) - 128;
         end
      end
   endtask

   // Monitor: pops the scoreboard on every pe_enable cycle, checks padding and done.
   initial begin : monitor
      exp_t e;
      int   cv;
      forever begin
         @(negedge clk);
         ncyc++;
         if (mon_en) begin
            if (in_valid && in_ready) begin
               mon_beats++;
               if (mon_beats == N) begin
                  mon_beats = 0;
                  acc_cyc   = ncyc;
               end
            end
            chk(in_ready == !busy, "ready_vs_busy", 64'(in_ready), 64'(!busy));
            chk(pe_enable == busy, "pe_enable", 64'(pe_enable), 64'(busy));
            chk(done == done_due, "done", 64'(done), 64'(done_due));
            if (done) begin
               nmat++;
               $display("matrix %0d done at cycle %0d", nmat, ncyc);
               chk(ncyc - acc_cyc == SLEN + DRAIN + 1, "done_latency",
                   64'(ncyc - acc_cyc), 64'(SLEN + DRAIN + 1));
               for (int i = 0; i < N; i++) begin
                  for (int j = 0; j < N; j++) begin
                     if (c_q.size() == 0) begin
                        chk(1'b0, "c_missing", 64'(i * N + j), 64'(0));
                     end else begin
                        cv = c_q.pop_front();
                        chk(acc_out[i][j] == cv, $sformatf("acc_out_%0d_%0d", i, j),
                            64'(acc_out[i][j]), 64'(cv));
                     end
                  end
               end
            end
            if (pe_enable) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_stream", 64'(a_west), 64'(0));
                  done_due = 1'b0;
               end else begin
                  e = exp_q.pop_front();
                  chk(a_west == e.a,  "a_west",  64'(a_west),  64'(e.a));
                  chk(b_north == e.b, "b_north", 64'(b_north), 64'(e.b));
                  done_due = e.last;
               end
            end else begin
               chk(a_west == '0 && b_north == '0, "pad_zero", {a_west, b_north}, 64'(0));
               done_due = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a_col = '0;
      in_b_row = '0;
      #3;
      check_quiet("por");
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Identity A, B[k][j] = 4k+j+1.
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[i][k] = (i == k) ? 1 : 0;
            mb[i][k] = 4 * i + k + 1;
         end
      send_matrix(N, 0);
      in_valid = 1'b0;
      wait_drain();

      // All operands at the most negative value.
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[i][k] = -128;
            mb[i][k] = -128;
         end
      send_matrix(N, 0);
      in_valid = 1'b0;
      wait_drain();

      // A[i][k] = i-k, B[k][j] = k+j through the PE array.
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[i][k] = i - k;
            mb[i][k] = i + k;
         end
      send_matrix(N, 0);
      in_valid = 1'b0;
      wait_drain();

      // Random operands with idle gaps between beats.
      for (int m = 0; m < 3; m++) begin
         rand_matrix();
         send_matrix(N, 3);
         in_valid = 1'b0;
         wait_drain();
      end

      // in_valid held high across back-to-back matrices.
      for (int m = 0; m < 3; m++) begin
         rand_matrix();
         send_matrix(N, 0);
      end
      in_valid = 1'b0;
      wait_drain();

      // Reset mid-LOAD: partial matrix discarded, next load starts at beat 0.
      rand_matrix();
      send_matrix(2, 0);
      in_valid = 1'b0;
      apply_reset();
      rand_matrix();
      send_matrix(N, 1);
      in_valid = 1'b0;
      wait_drain();

      // Reset mid-STREAM, then a clean reload.
      rand_matrix();
      send_matrix(N, 0);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      apply_reset();
      rand_matrix();
      send_matrix(N, 0);
      in_valid = 1'b0;
      wait_drain();

      repeat (3) @(posedge clk);
      chk(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
